bc_fifo: RTL and testbench

- Decoupled broadcast. Each DTI transfer accepted on din is copied into a private FIFO for every enabled output channel.
- Each output drains its FIFO independently, so a slow consumer stalls the producer only once its own FIFO is full. Fast consumers run ahead by up to DEPTH transfers.
- A per-transfer enable mask routes a transfer to any subset of outputs.
- Drop-in successor for the plain broadcast in pipelines where consumers have uneven latency.

---
 rtl/bc_fifo.sv | 115 +++++++++++
 tb/tb_bc_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_fifo.sv
// bc_fifo -- decoupled broadcast with one private FIFO per output channel.
//
// Each transfer accepted on din is written into the FIFO of every channel
// whose bit in ena is set. Each channel drains on its own. A slow consumer
// holds back the producer only when its own FIFO is full and the current
// transfer is addressed to it.
//
// Ports:
//   clk         clock; all logic runs on the rising edge
//   rst         synchronous reset, active-high; empties every FIFO
//   din_data    input payload, DIN_WIDTH bits
//   din_valid   input handshake valid
//   din_ready   input handshake ready; low during reset
//   ena         per-transfer channel mask, qualified by din_valid
//   dout_data   per-channel output payload, valid only while dout_valid[i]
//   dout_valid  per-channel output valid (FIFO not empty)
//   dout_ready  per-channel output ready
module bc_fifo #(
  parameter int SIZE      = 2,
  parameter int DIN_WIDTH = 16,
  parameter int DEPTH     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIN_WIDTH-1:0]            din_data,
  input  logic                            din_valid,
  output logic                            din_ready,
  input  logic [SIZE-1:0]                 ena,
  output logic [SIZE-1:0][DIN_WIDTH-1:0]  dout_data,
  output logic [SIZE-1:0]                 dout_valid,
  input  logic [SIZE-1:0]                 dout_ready
);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [SIZE-1:0] chan_full;
  logic            accept;

  // Ready depends only on registered full flags, the mask and reset, so no
  // downstream ready can reach upstream combinationally. A channel that is
  // not addressed by this transfer never blocks it.
  always_comb begin
    din_ready = ~rst & (&(~chan_full | ~ena));
    accept    = din_valid & din_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_chan
      logic [DIN_WIDTH-1:0] mem_q [DEPTH];
      logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]        cnt_q, cnt_d;
      logic                 full_q, full_d;
      logic                 empty_q, empty_d;
      logic                 wr_en;
      logic                 rd_en;

      always_comb begin
        wr_en    = accept & ena[gi];
        rd_en    = ~empty_q & dout_ready[gi];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // A simultaneous write and read leaves the occupancy unchanged.
        case ({wr_en, rd_en})
          2'b10:   cnt_d = cnt_q + CW'(1);
          2'b01:   cnt_d = cnt_q - CW'(1);
          default: cnt_d = cnt_q;
        endcase
        // Flags are registered alongside the count so ready stays shallow.
        full_d  = (cnt_d == CNT_FULL);
        empty_d = (cnt_d == '0);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
          full_q   <= 1'b0;
          empty_q  <= 1'b1;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
          full_q   <= full_d;
          empty_q  <= empty_d;
        end
      end

      // Storage needs no reset: contents are only observed while not empty.
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem_q[wr_ptr_q] <= din_data;
        end
      end

      // Asynchronous read of the head keeps first-word latency at one cycle.
      assign chan_full[gi]  = full_q;
      assign dout_valid[gi] = ~empty_q;
      assign dout_data[gi]  = mem_q[rd_ptr_q];
    end
  endgenerate

endmodule

// File: tb/tb_bc_fifo.sv
// tb_bc_fifo -- directed, table-driven bench for bc_fifo.
// u_dut uses SIZE=2, DEPTH=2; u_dut4 uses SIZE=2, DEPTH=4 for wrap-around.
module tb_bc_fifo;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      din_data;
  logic             din_valid;
  logic             din_ready;
  logic [1:0]       ena;
  logic [1:0][15:0] dout_data;
  logic [1:0]       dout_valid;
  logic [1:0]       dout_ready;

  logic [15:0]      din_data_4;
  logic             din_valid_4;
  logic             din_ready_4;
  logic [1:0]       ena_4;
  logic [1:0][15:0] dout_data_4;
  logic [1:0]       dout_valid_4;
  logic [1:0]       dout_ready_4;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bc_fifo #(.SIZE(2), .DIN_WIDTH(16), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .ena(ena),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  bc_fifo #(.SIZE(2), .DIN_WIDTH(16), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .din_data(din_data_4), .din_valid(din_valid_4), .din_ready(din_ready_4),
    .ena(ena_4),
    .dout_data(dout_data_4), .dout_valid(dout_valid_4), .dout_ready(dout_ready_4)
  );

  // Producer-side protocol: a stalled transfer must be held unchanged.
  logic        pend_q      = 1'b0;
  logic [15:0] pend_data_q = '0;
  always @(posedge clk) begin
    if (pend_q) begin
      assert (din_valid && din_data == pend_data_q)
        else $error("din protocol broken: payload withdrawn before ready");
    end
    pend_q      <= din_valid && !din_ready && !rst;
    pend_data_q <= din_data;
  end

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] d;
    logic        vl;
    logic [1:0]  e;
    logic [1:0]  r;
    logic        x_ready;
    logic [1:0]  x_valid;
    logic [15:0] x_d0;
    logic [15:0] x_d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [15:0] d, logic vl, logic [1:0] e, logic [1:0] r,
                              logic xr, logic [1:0] xv, logic [15:0] x0, logic [15:0] x1);
    vec_t v;
    v.d = d; v.vl = vl; v.e = e; v.r = r;
    v.x_ready = xr; v.x_valid = xv; v.x_d0 = x0; v.x_d1 = x1;
    return v;
  endfunction

  initial begin
    int sent;
    int got [2];
    int occ [2];
    bit done;

    // Slow consumer: channel 1 stalls until its FIFO fills, then drains.
    vecs.push_back(mk(16'hA0, 1, 2'b11, 2'b01, 1, 2'b00, 16'h0,  16'h0));
    vecs.push_back(mk(16'hA1, 1, 2'b11, 2'b01, 1, 2'b11, 16'hA0, 16'hA0));
    vecs.push_back(mk(16'hA2, 1, 2'b11, 2'b01, 0, 2'b11, 16'hA1, 16'hA0));
    vecs.push_back(mk(16'hA2, 1, 2'b11, 2'b11, 0, 2'b10, 16'h0,  16'hA0));
    vecs.push_back(mk(16'hA2, 1, 2'b11, 2'b11, 1, 2'b10, 16'h0,  16'hA1));
    vecs.push_back(mk(16'h0,  0, 2'b11, 2'b11, 1, 2'b11, 16'hA2, 16'hA2));
    vecs.push_back(mk(16'h0,  0, 2'b11, 2'b11, 1, 2'b00, 16'h0,  16'h0));
    // Mask routing, including an all-zero mask that is consumed and dropped.
    vecs.push_back(mk(16'h11, 1, 2'b01, 2'b11, 1, 2'b00, 16'h0,  16'h0));
    vecs.push_back(mk(16'h22, 1, 2'b10, 2'b11, 1, 2'b01, 16'h11, 16'h0));
    vecs.push_back(mk(16'h33, 1, 2'b11, 2'b11, 1, 2'b10, 16'h0,  16'h22));
    vecs.push_back(mk(16'h44, 1, 2'b00, 2'b11, 1, 2'b11, 16'h33, 16'h33));
    vecs.push_back(mk(16'h0,  0, 2'b00, 2'b11, 1, 2'b00, 16'h0,  16'h0));
    // Masked-full bypass: channel 1 full, a transfer for channel 0 only passes.
    vecs.push_back(mk(16'h50, 1, 2'b10, 2'b01, 1, 2'b00, 16'h0,  16'h0));
    vecs.push_back(mk(16'h51, 1, 2'b10, 2'b01, 1, 2'b10, 16'h0,  16'h50));
    vecs.push_back(mk(16'h0,  0, 2'b10, 2'b01, 0, 2'b10, 16'h0,  16'h50));
    vecs.push_back(mk(16'h55, 1, 2'b01, 2'b01, 1, 2'b10, 16'h0,  16'h50));
    vecs.push_back(mk(16'h0,  0, 2'b01, 2'b01, 1, 2'b11, 16'h55, 16'h50));
    vecs.push_back(mk(16'h0,  0, 2'b10, 2'b01, 0, 2'b10, 16'h0,  16'h50));
    vecs.push_back(mk(16'h0,  0, 2'b00, 2'b11, 1, 2'b10, 16'h0,  16'h50));
    vecs.push_back(mk(16'h0,  0, 2'b00, 2'b11, 1, 2'b10, 16'h0,  16'h51));
    vecs.push_back(mk(16'h0,  0, 2'b00, 2'b11, 1, 2'b00, 16'h0,  16'h0));

    rst = 1'b1;
    din_data = '0; din_valid = 1'b0; ena = 2'b11; dout_ready = 2'b00;
    din_data_4 = '0; din_valid_4 = 1'b0; ena_4 = 2'b11; dout_ready_4 = 2'b00;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("ready_in_reset", 0, 32'(din_ready), 32'h0);
    check("ready4_in_reset", 0, 32'(din_ready_4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 0, 32'(din_ready), 32'h1);
    check("valid_after_reset", 0, 32'(dout_valid), 32'h0);
    check("ready4_after_reset", 0, 32'(din_ready_4), 32'h1);
    check("valid4_after_reset", 0, 32'(dout_valid_4), 32'h0);

    // Back-to-back stream on both channels.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      din_data = 16'(k); din_valid = 1'b1; ena = 2'b11; dout_ready = 2'b11;
      #1;
      check("stream_ready", k, 32'(din_ready), 32'h1);
      if (k == 1) begin
        check("stream_valid", k, 32'(dout_valid), 32'h0);
      end else begin
        check("stream_valid", k, 32'(dout_valid), 32'h3);
        check("stream_d0", k, 32'(dout_data[0]), 32'(k - 1));
        check("stream_d1", k, 32'(dout_data[1]), 32'(k - 1));
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    check("stream_valid", 9, 32'(dout_valid), 32'h3);
    check("stream_d0", 9, 32'(dout_data[0]), 32'h8);
    check("stream_d1", 9, 32'(dout_data[1]), 32'h8);
    @(negedge clk);
    #1;
    check("stream_valid", 10, 32'(dout_valid), 32'h0);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      din_data = vecs[i].d; din_valid = vecs[i].vl;
      ena = vecs[i].e; dout_ready = vecs[i].r;
      #1;
      check("vec_ready", i, 32'(din_ready), 32'(vecs[i].x_ready));
      check("vec_valid", i, 32'(dout_valid), 32'(vecs[i].x_valid));
      if (vecs[i].x_valid[0]) check("vec_d0", i, 32'(dout_data[0]), 32'(vecs[i].x_d0));
      if (vecs[i].x_valid[1]) check("vec_d1", i, 32'(dout_data[1]), 32'(vecs[i].x_d1));
    end

    // Reset with both FIFOs full: contents are discarded.
    @(negedge clk);
    din_data = 16'h60; din_valid = 1'b1; ena = 2'b11; dout_ready = 2'b00;
    #1;
    check("rstmid_ready", 0, 32'(din_ready), 32'h1);
    @(negedge clk);
    din_data = 16'h61;
    #1;
    check("rstmid_ready", 1, 32'(din_ready), 32'h1);
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    check("rstmid_ready", 2, 32'(din_ready), 32'h0);
    check("rstmid_valid", 2, 32'(dout_valid), 32'h3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_ready", 3, 32'(din_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_valid", 4, 32'(dout_valid), 32'h0);
    check("rstmid_ready", 4, 32'(din_ready), 32'h1);
    @(negedge clk);
    din_data = 16'h77; din_valid = 1'b1; dout_ready = 2'b11;
    #1;
    check("rstmid_ready", 5, 32'(din_ready), 32'h1);
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    check("rstmid_valid", 6, 32'(dout_valid), 32'h3);
    check("rstmid_d0", 6, 32'(dout_data[0]), 32'h77);
    check("rstmid_d1", 6, 32'(dout_data[1]), 32'h77);
    @(negedge clk);
    #1;
    check("rstmid_valid", 7, 32'(dout_valid), 32'h0);

    // Wrap-around on DEPTH=4 with consumers ready every other cycle.
    sent = 0; got[0] = 0; got[1] = 0; occ[0] = 0; occ[1] = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      din_data_4  = 16'(sent);
      din_valid_4 = (sent < 16);
      ena_4       = 2'b11;
      dout_ready_4 = cyc[0] ? 2'b10 : 2'b01;
      #1;
      check("wrap_ready", cyc, 32'(din_ready_4), 32'(occ[0] < 4 && occ[1] < 4));
      for (int ch = 0; ch < 2; ch++) begin
        check("wrap_valid", cyc * 2 + ch, 32'(dout_valid_4[ch]), 32'(occ[ch] != 0));
        if (dout_valid_4[ch] && dout_ready_4[ch]) begin
          check("wrap_data", got[ch] * 2 + ch, 32'(dout_data_4[ch]), 32'(got[ch]));
          got[ch]++;
          occ[ch]--;
        end
      end
      if (din_valid_4 && din_ready_4) begin
        sent++;
        occ[0]++;
        occ[1]++;
      end
      done = (got[0] >= 16) && (got[1] >= 16);
    end
    check("wrap_count0", 0, 32'(got[0]), 32'd16);
    check("wrap_count1", 0, 32'(got[1]), 32'd16);
    @(negedge clk);
    din_valid_4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
